// File: rtl/md5_pkg.sv
// Shared constants and state encoding for the MD5 window sequencer.
package md5_pkg;

    localparam int STR_LEN = 19;
    localparam int LATENCY = 65;
    localparam int CNT_W   = 7;

    localparam logic [7:0]  PAD_MARKER = 8'h80;
    localparam logic [63:0] MSG_BITS   = 64'(STR_LEN * 8);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/md5_msg_pad.sv
// Builds a single padded 512-bit MD5 block from a STR_LEN-byte window.
module md5_msg_pad
    import md5_pkg::*;
(
    input  logic [STR_LEN*8-1:0] window,
    output logic [511:0]         block
);

    always_comb begin
        block = '0;
        block[511 -: STR_LEN*8]        = window;
        block[511 - 8*STR_LEN -: 8]    = PAD_MARKER;
        // Message bit length, little-endian in bytes 56..63
        for (int unsigned j = 0; j < 8; j++) begin
            block[511 - 8*(56 + j) -: 8] = MSG_BITS[8*j +: 8];
        end
    end

endmodule

// File: rtl/md5_window_sched.sv
// Slides a STR_LEN-byte window over the byte stream, feeds md5core one
// candidate per accepted byte, and latches the first digest match.
module md5_window_sched
    import md5_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] target,
    input  logic [7:0]   byte_in,
    input  logic         byte_valid,
    input  logic         byte_last,
    output logic         byte_ready,
    output logic         core_en,
    output logic [511:0] core_m,
    output logic         core_valid,
    input  logic [31:0]  core_a,
    input  logic [31:0]  core_b,
    input  logic [31:0]  core_c,
    input  logic [31:0]  core_d,
    input  logic [511:0] core_m_ret,
    input  logic         core_valid_ret,
    output logic         busy,
    output logic         done,
    output logic         match,
    output logic [151:0] match_str,
    output logic [31:0]  match_offset,
    output logic [31:0]  win_count
);

    state_t               state, state_nxt;
    logic [4:0]           fill_cnt;
    logic [STR_LEN*8-1:0] window, window_nxt;
    logic [127:0]         target_r;
    logic [CNT_W-1:0]     inflight;
    logic [31:0]          result_cnt;
    logic [511:0]         padded;
    logic                 accept, issue, last_fill, hit;
    logic                 unused_ret_bits;

    assign unused_ret_bits = ^core_m_ret[511 - 8*STR_LEN:0];

    assign window_nxt = {window[STR_LEN*8-9:0], byte_in};
    assign accept     = byte_valid && byte_ready;
    assign last_fill  = (fill_cnt == 5'(STR_LEN - 1));
    assign issue      = accept && ((state == ST_RUN) || last_fill);
    assign hit        = core_valid_ret && !match &&
                        ({core_a, core_b, core_c, core_d} == target_r);

    md5_msg_pad u_pad (
        .window (window_nxt),
        .block  (padded)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_FILL;
            ST_FILL: begin
                if (accept && byte_last)     state_nxt = ST_DRAIN;
                else if (accept && last_fill) state_nxt = ST_RUN;
            end
            ST_RUN:   if (match || (accept && byte_last)) state_nxt = ST_DRAIN;
            // core_valid still high means one candidate not yet counted in flight
            ST_DRAIN: if (inflight == '0 && !core_valid) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        byte_ready = 1'b0;
        core_en    = (state != ST_IDLE);
        busy       = (state != ST_IDLE);
        done       = (state == ST_DONE);
        case (state)
            ST_FILL: byte_ready = 1'b1;
            ST_RUN:  byte_ready = !match;
            default: byte_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            core_valid   <= 1'b0;
            core_m       <= '0;
            window       <= '0;
            fill_cnt     <= '0;
            target_r     <= '0;
            inflight     <= '0;
            result_cnt   <= '0;
            win_count    <= '0;
            match        <= 1'b0;
            match_str    <= '0;
            match_offset <= '0;
        end else begin
            core_valid <= issue;
            if (issue) core_m <= padded;

            if (state == ST_IDLE && start) begin
                target_r     <= target;
                fill_cnt     <= '0;
                inflight     <= '0;
                result_cnt   <= '0;
                win_count    <= '0;
                match        <= 1'b0;
                match_str    <= '0;
                match_offset <= '0;
            end else begin
                if (accept) begin
                    window <= window_nxt;
                    if (state == ST_FILL && !last_fill) fill_cnt <= fill_cnt + 5'd1;
                end
                if (issue && win_count != '1) win_count <= win_count + 32'd1;

                case ({core_valid, core_valid_ret})
                    2'b10:   inflight <= inflight + CNT_W'(1);
                    2'b01:   inflight <= inflight - CNT_W'(1);
                    default: inflight <= inflight;
                endcase

                if (core_valid_ret) result_cnt <= result_cnt + 32'd1;
                if (hit) begin
                    match        <= 1'b1;
                    match_str    <= core_m_ret[511 -: STR_LEN*8];
                    match_offset <= result_cnt;
                end
            end
        end
    end

endmodule

// File: tb/tb_md5_window_sched.sv
// Bench for md5_window_sched with a behavioural 65-cycle MD5 core model.
module tb_md5_window_sched;

    localparam int LAT = 65;
    localparam int unsigned SH [16] = '{7, 12, 17, 22, 5, 9, 14, 20,
                                        4, 11, 16, 23, 6, 10, 15, 21};

    logic         clk, reset, start;
    logic [127:0] target;
    logic [7:0]   byte_in;
    logic         byte_valid, byte_last, byte_ready;
    logic         core_en, core_valid, core_valid_ret;
    logic [511:0] core_m, core_m_ret;
    logic [31:0]  core_a, core_b, core_c, core_d;
    logic         busy, done, match;
    logic [151:0] match_str;
    logic [31:0]  match_offset, win_count;

    md5_window_sched dut (
        .clk(clk), .reset(reset), .start(start), .target(target),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_last(byte_last),
        .byte_ready(byte_ready), .core_en(core_en), .core_m(core_m),
        .core_valid(core_valid), .core_a(core_a), .core_b(core_b),
        .core_c(core_c), .core_d(core_d), .core_m_ret(core_m_ret),
        .core_valid_ret(core_valid_ret), .busy(busy), .done(done),
        .match(match), .match_str(match_str), .match_offset(match_offset),
        .win_count(win_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] kconst(input int i);
        real x;
        x = $sin(real'(i + 1));
        if (x < 0.0) x = -x;
        return 32'(longint'($floor(x * 4294967296.0)));
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] v, input int unsigned s);
        return (v << s) | (v >> (32 - s));
    endfunction

    function automatic logic [127:0] md5_blk(input logic [511:0] blk);
        logic [31:0] w [16];
        logic [31:0] a, b, c, d, f, t;
        int g;
        for (int i = 0; i < 16; i++)
            w[i] = {blk[511-8*(4*i+3) -: 8], blk[511-8*(4*i+2) -: 8],
                    blk[511-8*(4*i+1) -: 8], blk[511-8*(4*i) -: 8]};
        a = 32'h67452301; b = 32'hefcdab89; c = 32'h98badcfe; d = 32'h10325476;
        for (int i = 0; i < 64; i++) begin
            if (i < 16)      begin f = (b & c) | (~b & d); g = i; end
            else if (i < 32) begin f = (d & b) | (~d & c); g = (5*i + 1) % 16; end
            else if (i < 48) begin f = b ^ c ^ d;          g = (3*i + 5) % 16; end
            else             begin f = c ^ (b | ~d);       g = (7*i) % 16; end
            t = d; d = c; c = b;
            b = b + rotl(a + f + kconst(i) + w[g], SH[(i/16)*4 + (i%4)]);
            a = t;
        end
        return {a + 32'h67452301, b + 32'hefcdab89, c + 32'h98badcfe, d + 32'h10325476};
    endfunction

    function automatic logic [511:0] pad19(input logic [151:0] win);
        logic [511:0] b;
        b = '0;
        b[511:360] = win;
        b[359:352] = 8'h80;
        b[63:56]   = 8'h98;
        return b;
    endfunction

    function automatic logic [151:0] str152(input string s);
        logic [151:0] w;
        w = '0;
        for (int i = 0; i < 19; i++) w = {w[143:0], s[i]};
        return w;
    endfunction

    // Core model: in-order pipeline, advances only while en is high
    logic [511:0] pm [LAT];
    logic [127:0] pd [LAT];
    logic         pv [LAT];

    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < LAT; k++) pv[k] <= 1'b0;
        end else if (core_en) begin
            pv[0] <= core_valid;
            pm[0] <= core_m;
            pd[0] <= core_valid ? md5_blk(core_m) : '0;
            for (int k = 1; k < LAT; k++) begin
                pv[k] <= pv[k-1];
                pm[k] <= pm[k-1];
                pd[k] <= pd[k-1];
            end
        end
    end

    assign core_valid_ret = pv[LAT-1];
    assign core_m_ret     = pm[LAT-1];
    assign {core_a, core_b, core_c, core_d} = pd[LAT-1];

    int total = 0, bad = 0;
    int cyc = 0;
    int done_cnt = 0, done_cyc = 0, issue_cyc = 0, last_acc_cyc = 0, rises = 0;
    logic         cv_q = 1'b0;
    logic [511:0] last_m;
    logic [511:0] exp_q [$];
    logic [7:0]   txt [128];
    int           txt_n;
    logic [151:0] bw;
    int           n_acc;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Candidate scoreboard and event monitor
    initial forever begin
        logic [511:0] e;
        @(negedge clk);
        if (core_valid) begin
            issue_cyc = cyc;
            last_m = core_m;
            if (!cv_q) rises++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL cand_unexpected: got core_m=%h want no candidate", core_m);
            end else begin
                e = exp_q.pop_front();
                if (core_m !== e) begin
                    bad++;
                    $display("FAIL cand_m: got %h want %h", core_m, e);
                end
            end
        end
        cv_q = core_valid;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic load_text(input string s);
        txt_n = s.len();
        for (int i = 0; i < txt_n; i++) txt[i] = s[i];
    endtask

    task automatic begin_search(input logic [127:0] tgt);
        @(negedge clk);
        target = tgt;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        bw = '0; n_acc = 0; rises = 0;
    endtask

    task automatic send_stream(input int gap);
        for (int i = 0; i < txt_n; i++) begin
            for (int g = 0; g < gap; g++) begin
                byte_valid = 1'b0;
                @(negedge clk);
            end
            byte_in    = txt[i];
            byte_valid = 1'b1;
            byte_last  = (i == txt_n - 1);
            if (!byte_ready) break;
            bw = {bw[143:0], txt[i]};
            n_acc++;
            last_acc_cyc = cyc;
            if (n_acc >= 19) exp_q.push_back(pad19(bw));
            @(negedge clk);
        end
        byte_valid = 1'b0;
        byte_last  = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        for (int i = 0; i < 400 && done_cnt == d0; i++) @(negedge clk);
        if (done_cnt == d0) begin
            total++; bad++;
            $display("FAIL done_timeout: got no done want done within 400 cycles");
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic check_quick_result(input string tag);
        total++;
        if (match !== 1'b1) begin bad++; $display("FAIL %s_match: got %0b want 1", tag, match); end
        total++;
        if (match_offset !== 32'd4) begin bad++; $display("FAIL %s_offset: got %0d want 4", tag, match_offset); end
        total++;
        if (match_str !== str152("quick brown fox jum")) begin
            bad++; $display("FAIL %s_str: got %h want %h", tag, match_str, str152("quick brown fox jum"));
        end
    endtask

    logic [127:0] quick_tgt;

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({byte_ready, core_en, core_valid, busy, done, match} !== 6'b0) begin
            bad++; $display("FAIL reset_flags: got %b want 000000", {byte_ready, core_en, core_valid, busy, done, match});
        end
        total++;
        if ({win_count, match_offset} !== 64'd0) begin
            bad++; $display("FAIL reset_counts: got %0d/%0d want 0/0", win_count, match_offset);
        end
        total++;
        if (core_m !== '0 || match_str !== '0) begin
            bad++; $display("FAIL reset_data: got nonzero want zero");
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_quick();
        int d0;
        load_text("The quick brown fox jumps");
        d0 = done_cnt;
        begin_search(quick_tgt);
        send_stream(0);
        wait_done(d0);
        check_quick_result("quick");
        total++;
        if (win_count > 32'd7) begin bad++; $display("FAIL quick_wincount: got %0d want <=7", win_count); end
        total++;
        if (done_cnt - d0 !== 1) begin bad++; $display("FAIL quick_done_once: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_random();
        int d0;
        txt_n = 100;
        for (int i = 0; i < 100; i++) txt[i] = 8'($urandom);
        d0 = done_cnt;
        begin_search('0);
        send_stream(0);
        wait_done(d0);
        total++;
        if (match !== 1'b0) begin bad++; $display("FAIL rand_match: got %0b want 0", match); end
        total++;
        if (win_count !== 32'd82) begin bad++; $display("FAIL rand_wincount: got %0d want 82", win_count); end
        total++;
        if (done_cyc - issue_cyc < 66) begin
            bad++; $display("FAIL rand_drain_gap: got %0d want >=66", done_cyc - issue_cyc);
        end
    endtask

    task automatic test_exact19();
        int d0;
        load_text("quick brown fox jum");
        d0 = done_cnt;
        begin_search(quick_tgt);
        send_stream(0);
        wait_done(d0);
        total++;
        if (win_count !== 32'd1) begin bad++; $display("FAIL x19_wincount: got %0d want 1", win_count); end
        total++;
        if (match !== 1'b1 || match_offset !== 32'd0) begin
            bad++; $display("FAIL x19_match: got %0b@%0d want 1@0", match, match_offset);
        end
        total++;
        if (last_m[359:352] !== 8'h80) begin bad++; $display("FAIL x19_byte19: got %h want 80", last_m[359:352]); end
        total++;
        if (last_m[63:56] !== 8'h98) begin bad++; $display("FAIL x19_byte56: got %h want 98", last_m[63:56]); end
    endtask

    task automatic test_short();
        int d0;
        load_text("quick brow");
        d0 = done_cnt;
        begin_search(quick_tgt);
        send_stream(0);
        wait_done(d0);
        total++;
        if (win_count !== 32'd0) begin bad++; $display("FAIL short_wincount: got %0d want 0", win_count); end
        total++;
        if (match !== 1'b0) begin bad++; $display("FAIL short_match: got %0b want 0", match); end
        total++;
        if (done_cyc - last_acc_cyc > 3) begin
            bad++; $display("FAIL short_done_delay: got %0d want <=3", done_cyc - last_acc_cyc);
        end
    endtask

    task automatic test_bubbles();
        int d0;
        load_text("The quick brown fox jumps");
        d0 = done_cnt;
        begin_search(quick_tgt);
        send_stream(1);
        wait_done(d0);
        check_quick_result("bubble");
        total++;
        if (rises < 2) begin bad++; $display("FAIL bubble_toggle: got %0d rises want >=2", rises); end
    endtask

    task automatic test_reset_mid();
        int d0;
        load_text("The quick brown fox jumps");
        d0 = done_cnt;
        begin_search(quick_tgt);
        send_stream(0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({byte_ready, core_en, core_valid, busy, done, match} !== 6'b0) begin
            bad++; $display("FAIL midreset_flags: got %b want 000000", {byte_ready, core_en, core_valid, busy, done, match});
        end
        total++;
        if ({win_count, match_offset} !== 64'd0 || core_m !== '0) begin
            bad++; $display("FAIL midreset_data: got wc=%0d off=%0d want 0/0", win_count, match_offset);
        end
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        total++;
        if (done_cnt !== d0) begin bad++; $display("FAIL midreset_nodone: got %0d pulses want 0", done_cnt - d0); end
        d0 = done_cnt;
        begin_search(quick_tgt);
        send_stream(0);
        wait_done(d0);
        check_quick_result("rerun");
    endtask

    initial begin
        start = 1'b0; target = '0; byte_in = '0; byte_valid = 1'b0; byte_last = 1'b0;
        quick_tgt = md5_blk(pad19(str152("quick brown fox jum")));
        test_reset();
        test_quick();
        test_random();
        test_exact19();
        test_short();
        test_bubbles();
        test_reset_mid();
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL leftover_candidates: got %0d want 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
